// File: rtl/accel_reg_engine_pkg.sv
// -----------------------------------------------------------------------------
// accel_reg_engine_pkg
// Shared definitions for the accelerometer SPI register engine:
//   - FSM state encoding
//   - register map addresses
//   - STATUS register bit positions
//   - command byte field positions
//   - read-only address classification helper
// -----------------------------------------------------------------------------
package accel_reg_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [5:0] WHO_AM_I_ADDR = 6'h0F;
  localparam logic [5:0] STATUS_ADDR   = 6'h27;
  localparam logic [5:0] OUT_X_L       = 6'h28;
  localparam logic [5:0] OUT_X_H       = 6'h29;
  localparam logic [5:0] OUT_Y_L       = 6'h2A;
  localparam logic [5:0] OUT_Y_H       = 6'h2B;
  localparam logic [5:0] OUT_Z_L       = 6'h2C;
  localparam logic [5:0] OUT_Z_H       = 6'h2D;

  localparam int unsigned STATUS_ZYXDA_BIT = 3;
  localparam int unsigned STATUS_ZYXOR_BIT = 7;

  localparam int unsigned CMD_RNW_BIT  = 7;
  localparam int unsigned CMD_MS_BIT   = 6;
  localparam int unsigned CMD_ADDR_MSB = 5;

  function automatic logic is_read_only(input logic [5:0] addr);
    return (addr == WHO_AM_I_ADDR) ||
           (addr == STATUS_ADDR)   ||
           ((addr >= OUT_X_L) && (addr <= OUT_Z_H));
  endfunction

endpackage

// File: rtl/accel_reg_engine_regfile.sv
// -----------------------------------------------------------------------------
// accel_regfile
// 64x8 register storage for the accelerometer register engine.
//   i_clk, i_rst          : clock, synchronous active-high reset (clears all)
//   i_wr_en/addr/data     : host write port; read-only addresses are dropped
//   i_rd_addr, o_rd_data  : combinational read port (WHO_AM_I and STATUS muxed in)
//   i_sample_we, i_sample_*: accepted accelerometer sample, loads OUT_* regs
//   i_status_clr          : clears ZYXDA/ZYXOR (OUT_Z_H has been read)
// -----------------------------------------------------------------------------
module accel_regfile
  import accel_reg_engine_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I = 8'h33,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  input  logic              i_sample_we,
  input  logic [15:0]       i_sample_x,
  input  logic [15:0]       i_sample_y,
  input  logic [15:0]       i_sample_z,
  input  logic              i_status_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] r_mem [DEPTH];
  logic       r_zyxda;
  logic       r_zyxor;
  logic [7:0] w_status;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem   <= '{default: '0};
      r_zyxda <= 1'b0;
      r_zyxor <= 1'b0;
    end else begin
      if (i_wr_en && !is_read_only(i_wr_addr)) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_status_clr) begin
        r_zyxda <= 1'b0;
        r_zyxor <= 1'b0;
      end
      // Samples only arrive with chip-select idle, so they never race a
      // host write or a status clear; giving them last word is harmless.
      if (i_sample_we) begin
        r_mem[OUT_X_L] <= i_sample_x[7:0];
        r_mem[OUT_X_H] <= i_sample_x[15:8];
        r_mem[OUT_Y_L] <= i_sample_y[7:0];
        r_mem[OUT_Y_H] <= i_sample_y[15:8];
        r_mem[OUT_Z_L] <= i_sample_z[7:0];
        r_mem[OUT_Z_H] <= i_sample_z[15:8];
        r_zyxda        <= 1'b1;
        r_zyxor        <= r_zyxor | r_zyxda;
      end
    end
  end

  always_comb begin
    w_status                   = '0;
    w_status[STATUS_ZYXDA_BIT] = r_zyxda;
    w_status[STATUS_ZYXOR_BIT] = r_zyxor;
  end

  always_comb begin
    o_rd_data = r_mem[i_rd_addr];
    if (i_rd_addr == WHO_AM_I_ADDR) begin
      o_rd_data = WHO_AM_I;
    end else if (i_rd_addr == STATUS_ADDR) begin
      o_rd_data = w_status;
    end
  end

endmodule

// File: rtl/accel_reg_engine.sv
// -----------------------------------------------------------------------------
// accel_reg_engine
// SPI-side register engine for an accelerometer: decodes command bytes from an
// SPI byte receiver, performs single/burst register reads and writes, and
// accepts new samples from the sensor path while chip-select is idle.
//   sys_clk, sys_rst         : clock, synchronous active-high reset
//   cs_active                : synchronised SPI chip-select
//   rx_valid, rx_data        : received byte strobe and data
//   tx_data, tx_load         : next byte to shift out and its load strobe
//   sample_valid/ready       : sample handshake (ready only while CS idle)
//   sample_x/y/z             : signed 16-bit accelerometer sample
// -----------------------------------------------------------------------------
module accel_reg_engine
  import accel_reg_engine_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I = 8'h33,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cs_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rnw;
  logic              r_ms;
  logic              r_cs_block;
  logic [7:0]        r_tx_data;
  logic              r_tx_load;

  logic              w_cmd_fire;
  logic              w_xfer_fire;
  logic              w_cmd_rnw;
  logic              w_cmd_ms;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_rd_data;
  logic              w_rd_load;
  logic              w_wr_en;
  logic              w_status_clr;
  logic              w_sample_we;

  always_comb begin
    w_cmd_fire   = (r_state == ST_CMD)  && cs_active && rx_valid;
    w_xfer_fire  = (r_state == ST_XFER) && cs_active && rx_valid;
    w_cmd_rnw    = rx_data[CMD_RNW_BIT];
    w_cmd_ms     = rx_data[CMD_MS_BIT];
    w_cmd_addr   = rx_data[CMD_ADDR_MSB:0];
    // Address wraps naturally at the top of the map.
    w_addr_next  = r_ms ? r_addr + ADDR_W'(1) : r_addr;
    // Command-byte reads fetch the start address; burst reads fetch the
    // address after advancing. Both share one read port.
    w_rd_addr    = w_cmd_fire ? w_cmd_addr : w_addr_next;
    w_rd_load    = (w_cmd_fire && w_cmd_rnw) || (w_xfer_fire && r_rnw);
    w_wr_en      = w_xfer_fire && !r_rnw;
    w_status_clr = w_rd_load && (w_rd_addr == OUT_Z_H);
    sample_ready = !cs_active && !sys_rst;
    w_sample_we  = sample_valid && sample_ready;
  end

  accel_regfile #(
    .WHO_AM_I (WHO_AM_I),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .i_clk        (sys_clk),
    .i_rst        (sys_rst),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (r_addr),
    .i_wr_data    (rx_data),
    .i_rd_addr    (w_rd_addr),
    .o_rd_data    (w_rd_data),
    .i_sample_we  (w_sample_we),
    .i_sample_x   (sample_x),
    .i_sample_y   (sample_y),
    .i_sample_z   (sample_z),
    .i_status_clr (w_status_clr)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rnw      <= 1'b0;
      r_ms       <= 1'b0;
      r_cs_block <= 1'b1;
      r_tx_data  <= '0;
      r_tx_load  <= 1'b0;
    end else begin
      r_tx_load <= w_rd_load;
      if (w_rd_load) begin
        r_tx_data <= w_rd_data;
      end

      // After a reset, a chip-select that is still held belongs to the
      // aborted transfer; wait for it to drop before accepting a new one.
      if (!cs_active) begin
        r_cs_block <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (cs_active && !r_cs_block) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!cs_active) begin
            r_state <= ST_IDLE;
          end else if (rx_valid) begin
            r_rnw   <= w_cmd_rnw;
            r_ms    <= w_cmd_ms;
            r_addr  <= w_cmd_addr;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!cs_active) begin
            r_state <= ST_IDLE;
          end else if (rx_valid) begin
            r_addr <= w_addr_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data = r_tx_data;
  assign tx_load = r_tx_load;

endmodule

// File: tb/tb_accel_reg_engine.sv
module tb_accel_reg_engine;

  logic        sys_clk;
  logic        sys_rst;
  logic        cs_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;

  accel_reg_engine #(
    .WHO_AM_I (8'h33),
    .ADDR_W   (6)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cs_active    (cs_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every tx_load must match the oldest expectation, both in data
  // and in the cycle it appears (one cycle after the triggering rx_valid).
  always @(negedge sys_clk) begin
    if (tx_load === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tx_load: got tx_data=0x%02h at cycle %0d, required no tx_load",
                 tx_data, cyc);
      end else begin
        m_e = sb.pop_front();
        if (tx_data !== m_e.data || cyc != m_e.cyc) begin
          n_fail++;
          $display("FAIL %s: got tx_data=0x%02h at cycle %0d, required 0x%02h at cycle %0d",
                   m_e.name, tx_data, cyc, m_e.data, m_e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Sends one byte; when exp_tx is set, a tx_load of exp_data is expected
  // on the cycle right after this byte's rx_valid is sampled.
  task automatic spi_byte(input logic [7:0] b, input bit exp_tx,
                          input logic [7:0] exp_data, input string name);
    exp_t e;
    if (exp_tx) begin
      e.data = exp_data;
      e.cyc  = cyc + 1;
      e.name = name;
      sb.push_back(e);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
  endtask

  task automatic cs_on();
    cs_active = 1'b1;
    tick();
    tick();
  endtask

  task automatic cs_off();
    cs_active = 1'b0;
    tick();
    tick();
  endtask

  task automatic rd1(input logic [7:0] cmd, input logic [7:0] exp, input string name);
    cs_on();
    spi_byte(cmd, 1'b1, exp, name);
    cs_off();
  endtask

  task automatic rd_burst(input logic [7:0] cmd, input logic [7:0] exp[], input string name);
    cs_on();
    for (int i = 0; i < exp.size(); i++) begin
      spi_byte((i == 0) ? cmd : 8'hA5, 1'b1, exp[i], $sformatf("%s[%0d]", name, i));
    end
    cs_off();
  endtask

  task automatic wr_burst(input logic [7:0] cmd, input logic [7:0] d[]);
    cs_on();
    spi_byte(cmd, 1'b0, 8'h00, "");
    for (int i = 0; i < d.size(); i++) spi_byte(d[i], 1'b0, 8'h00, "");
    cs_off();
  endtask

  task automatic give_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  initial begin
    sys_rst      = 1'b1;
    cs_active    = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    sample_valid = 1'b0;
    sample_x     = '0;
    sample_y     = '0;
    sample_z     = '0;
    tick();
    tick();
    check("ready_in_reset", {31'd0, sample_ready}, 32'd0);
    sys_rst = 1'b0;
    tick();
    check("reset_tx_load", {31'd0, tx_load}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("ready_idle", {31'd0, sample_ready}, 32'd1);
    tick();

    // WHO_AM_I and reset state of STATUS
    rd1(8'h8F, 8'h33, "who_am_i");
    rd1(8'hA7, 8'h00, "status_after_reset");

    // Burst write with auto-increment, then single and non-increment reads
    wr_burst(8'h50, '{8'h11, 8'h22});
    rd1(8'h90, 8'h11, "rd_0x10");
    rd1(8'h91, 8'h22, "rd_0x11");
    rd_burst(8'h90, '{8'h11, 8'h11}, "rd_hold_0x10");

    // Sample capture and burst read of the output registers
    give_sample(16'h1234, 16'hFFFE, 16'h8000);
    rd1(8'hA7, 8'h08, "status_one_sample");
    rd_burst(8'hE8, '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'h00}, "out_burst");
    rd1(8'hA7, 8'h00, "status_cleared");

    // Overrun, then a sample held across an active transfer
    give_sample(16'h0102, 16'h0304, 16'h0506);
    give_sample(16'h1122, 16'h3344, 16'h5566);
    rd1(8'hA7, 8'h88, "status_overrun");
    sample_x     = 16'hAAAA;
    sample_y     = 16'hBBBB;
    sample_z     = 16'hCCCC;
    sample_valid = 1'b1;
    cs_active    = 1'b1;
    tick();
    check("ready_cs_rise", {31'd0, sample_ready}, 32'd0);
    tick();
    spi_byte(8'hE8, 1'b1, 8'h22, "held_x_l");
    spi_byte(8'hA5, 1'b1, 8'h11, "held_x_h");
    spi_byte(8'hA5, 1'b1, 8'h44, "held_y_l");
    spi_byte(8'hA5, 1'b1, 8'h33, "held_y_h");
    spi_byte(8'hA5, 1'b1, 8'h66, "held_z_l");
    spi_byte(8'hA5, 1'b1, 8'h55, "held_z_h");
    check("ready_during_xfer", {31'd0, sample_ready}, 32'd0);
    cs_active = 1'b0;
    tick();
    sample_valid = 1'b0;
    tick();
    rd1(8'hA7, 8'h08, "status_after_held");
    rd_burst(8'hE8, '{8'hAA, 8'hAA, 8'hBB}, "held_capture");

    // Address wrap and read-only drops
    wr_burst(8'h7F, '{8'hA1, 8'hB2, 8'hC3});
    rd_burst(8'hFF, '{8'hA1, 8'hB2, 8'hC3}, "wrap");
    wr_burst(8'h0F, '{8'h55});
    rd1(8'h8F, 8'h33, "who_am_i_ro");
    wr_burst(8'h4E, '{8'h12, 8'h34, 8'h56});
    rd_burst(8'hCE, '{8'h12, 8'h33, 8'h56}, "ro_skip_advance");

    // Reset in the middle of a burst write with chip-select still held
    cs_on();
    spi_byte(8'h40, 1'b0, 8'h00, "");
    spi_byte(8'h01, 1'b0, 8'h00, "");
    spi_byte(8'h02, 1'b0, 8'h00, "");
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    spi_byte(8'h03, 1'b0, 8'h00, "");
    spi_byte(8'h04, 1'b0, 8'h00, "");
    spi_byte(8'h80, 1'b0, 8'h00, "");
    spi_byte(8'hFF, 1'b0, 8'h00, "");
    cs_off();
    rd_burst(8'hC0, '{8'h00, 8'h00, 8'h00}, "post_rst_low");
    rd1(8'hBF, 8'h00, "post_rst_3f");
    rd1(8'h90, 8'h00, "post_rst_10");
    rd1(8'h8E, 8'h00, "post_rst_0e");
    rd1(8'hA7, 8'h00, "post_rst_status");
    rd1(8'hA8, 8'h00, "post_rst_x_l");
    rd1(8'h8F, 8'h33, "post_rst_who");

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
